// File: rtl/uart_tx_fifo.sv
// Byte FIFO draining into an 8N1 UART transmitter, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx_fifo #(
    parameter int unsigned CLK_FREQ   = 20000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       fifo_full,
    output logic       fifo_empty,
    output logic [1:0] fifo_state,
    output logic       overflow,
    output logic       tx_busy,
    output logic       tx
);

    localparam int unsigned DIV   = CLK_FREQ / BAUD;
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BaudW = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    state_e            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              fifo_full_q, fifo_full_d, fifo_empty_q, fifo_empty_d;
    logic [1:0]        fifo_state_q, fifo_state_d;
    logic              overflow_q, overflow_d;
    logic              push, pop, baud_last;

    assign baud_last = (baud_q == BaudW'(DIV - 1));

    // Serialiser; tx is registered from the current state, so it trails state by one cycle.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_last ? '0 : baud_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = 1'b1;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            StIdle: begin
                baud_d = '0;
                if (!fifo_empty_q) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                tx_d = 1'b0;
                if (baud_last) begin
                    state_d   = StData;
                    bit_idx_d = 3'd0;
                end
            end
            StData: begin
                tx_d = shift_q[0];
                if (baud_last) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                tx_d = parity_q;
                if (baud_last) state_d = StStop;
            end
`endif
            StStop: begin
                tx_d = 1'b1;
                if (baud_last) begin
                    if (!fifo_empty_q) begin
                        pop     = 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (pop) begin
            shift_d  = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            parity_d = ^mem_q[rd_ptr_q];
`endif
        end
    end

    // FIFO bookkeeping; a write while full is dropped even if a pop frees a slot this cycle.
    always_comb begin
        push         = wr_en && !fifo_full_q;
        overflow_d   = overflow_q | (wr_en & fifo_full_q);
        wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d      = count_q + CntW'(push) - CntW'(pop);
        fifo_full_d  = (count_d == CntW'(FIFO_DEPTH));
        fifo_empty_d = (count_d == '0);
        if (count_d == '0) begin
            fifo_state_d = 2'b00;
        end else if (count_d < CntW'(FIFO_DEPTH / 2)) begin
            fifo_state_d = 2'b01;
        end else if (count_d < CntW'(FIFO_DEPTH)) begin
            fifo_state_d = 2'b10;
        end else begin
            fifo_state_d = 2'b11;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            baud_q       <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            tx_q         <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            fifo_full_q  <= 1'b0;
            fifo_empty_q <= 1'b1;
            fifo_state_q <= 2'b00;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            fifo_full_q  <= fifo_full_d;
            fifo_empty_q <= fifo_empty_d;
            fifo_state_q <= fifo_state_d;
            overflow_q   <= overflow_d;
        end
    end

    assign fifo_full  = fifo_full_q;
    assign fifo_empty = fifo_empty_q;
    assign fifo_state = fifo_state_q;
    assign overflow   = overflow_q;
    assign tx_busy    = (state_q != StIdle);
    assign tx         = tx_q;

endmodule
